// File: rtl/falafel_pkg.sv
// falafel_pkg: shared data width, config command record and writer FSM states
package falafel_pkg;

   localparam int DATA_W = 8;

   typedef struct packed {
      logic [DATA_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } cfg_cmd_t;

   typedef enum logic [1:0] {
      IDLE,
      WRITE,
      GAP
   } cfg_writer_state_e;

endpackage

// File: rtl/falafel_cfg_fifo.sv
// falafel_cfg_fifo: synchronous FIFO of config commands with flush and occupancy count
module falafel_cfg_fifo
   import falafel_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic                       push_i,
   input  cfg_cmd_t                   push_cmd_i,
   input  logic                       pop_i,
   input  logic                       flush_i,
   output cfg_cmd_t                   head_o,
   output logic                       full_o,
   output logic                       empty_o,
   output logic [$clog2(DEPTH+1)-1:0] count_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);

   cfg_cmd_t      r_mem [DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [CW-1:0] r_count;
   logic          w_push;
   logic          w_pop;

   // full/empty come straight from the registered count; flush kills both push and pop
   assign full_o  = (r_count == CW'(DEPTH));
   assign empty_o = (r_count == '0);
   assign w_push  = push_i && !full_o && !flush_i;
   assign w_pop   = pop_i && !empty_o && !flush_i;
   assign head_o  = r_mem[r_rd_ptr];
   assign count_o = r_count;

   // storage array, no reset needed since occupancy is tracked by r_count
   always_ff @(posedge clk_i) begin
      if (w_push) r_mem[r_wr_ptr] <= push_cmd_i;
   end

   // pointers wrap naturally because DEPTH is a power of two
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (flush_i) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
         r_count <= r_count + CW'(w_push) - CW'(w_pop);
      end
   end

endmodule

// File: rtl/falafel_config_writer.sv
// falafel_config_writer: buffers (addr,data) commands and replays them as single-cycle
// config-register write pulses with a programmable idle gap; out-of-range addresses are
// dropped and flagged. Define FALAFEL_CFG_WRITER_STATS_EN to add saturating pulse/drop counters.
module falafel_config_writer
   import falafel_pkg::*;
#(
   parameter int FIFO_DEPTH = 4,
   parameter int GAP_CYCLES = 0,
   parameter int ADDR_LIMIT = 16
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              cmd_valid_i,
   output logic              cmd_ready_o,
   input  logic [DATA_W-1:0] cmd_addr_i,
   input  logic [DATA_W-1:0] cmd_data_i,
   input  logic              flush_i,
   output logic              write_o,
   output logic [DATA_W-1:0] addr_o,
   output logic [DATA_W-1:0] data_o,
   output logic              busy_o,
   output logic              err_o,
   output logic [DATA_W-1:0] err_addr_o
`ifdef FALAFEL_CFG_WRITER_STATS_EN
   ,
   output logic [31:0]       wr_count_o,
   output logic [15:0]       drop_count_o
`endif
);

   localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
   localparam int CW = $clog2(FIFO_DEPTH + 1);
   localparam logic [DATA_W:0] LIMIT = (DATA_W + 1)'(ADDR_LIMIT);

   cfg_writer_state_e r_state;
   logic [GW-1:0]     r_gap_cnt;
   logic              r_write;
   logic [DATA_W-1:0] r_addr;
   logic [DATA_W-1:0] r_data;
   logic              r_err;
   logic [DATA_W-1:0] r_err_addr;
   cfg_cmd_t          w_cmd;
   cfg_cmd_t          w_head;
   logic              w_full;
   logic              w_empty;
   logic [CW-1:0]     w_count;
   logic              w_slot;
   logic              w_pop;
   logic              w_legal;

   assign w_cmd = '{addr: cmd_addr_i, data: cmd_data_i};

   falafel_cfg_fifo #(
      .DEPTH(FIFO_DEPTH)
   ) u_fifo (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .push_i    (cmd_valid_i),
      .push_cmd_i(w_cmd),
      .pop_i     (w_pop),
      .flush_i   (flush_i),
      .head_o    (w_head),
      .full_o    (w_full),
      .empty_o   (w_empty),
      .count_o   (w_count)
   );

   // a pop slot exists in IDLE, in WRITE when back-to-back, and in the last GAP cycle so
   // that exactly GAP_CYCLES idle cycles separate consecutive pulses
   assign w_slot  = (r_state == IDLE) ||
                    ((r_state == WRITE) && (GAP_CYCLES == 0)) ||
                    ((r_state == GAP) && (r_gap_cnt == '0));
   assign w_pop   = w_slot && !w_empty && !flush_i;
   assign w_legal = {1'b0, w_head.addr} < LIMIT;

   assign cmd_ready_o = !w_full;
   assign busy_o      = (w_count != '0) || (r_state != IDLE);
   assign write_o     = r_write;
   assign addr_o      = r_addr;
   assign data_o      = r_data;
   assign err_o       = r_err;
   assign err_addr_o  = r_err_addr;

   // issue FSM: pops the head, emits a registered pulse or records a drop, then times the gap
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state    <= IDLE;
         r_gap_cnt  <= '0;
         r_write    <= 1'b0;
         r_addr     <= '0;
         r_data     <= '0;
         r_err      <= 1'b0;
         r_err_addr <= '0;
      end else begin
         r_write <= 1'b0;
         if (w_pop) begin
            if (w_legal) begin
               r_state <= WRITE;
               r_write <= 1'b1;
               r_addr  <= w_head.addr;
               r_data  <= w_head.data;
            end else begin
               r_state <= IDLE;
               r_err   <= 1'b1;
               if (!r_err) r_err_addr <= w_head.addr;
            end
         end else if ((r_state == WRITE) && (GAP_CYCLES > 0)) begin
            r_state   <= GAP;
            r_gap_cnt <= GW'(GAP_CYCLES - 1);
         end else if ((r_state == GAP) && (r_gap_cnt != '0)) begin
            r_gap_cnt <= r_gap_cnt - 1'b1;
         end else begin
            r_state <= IDLE;
         end
      end
   end

`ifdef FALAFEL_CFG_WRITER_STATS_EN
   logic [31:0] r_wr_count;
   logic [15:0] r_drop_count;

   assign wr_count_o   = r_wr_count;
   assign drop_count_o = r_drop_count;

   // saturating counters of issued pulses and dropped commands
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_wr_count   <= '0;
         r_drop_count <= '0;
      end else begin
         if (r_write && (r_wr_count != '1)) r_wr_count <= r_wr_count + 32'd1;
         if (w_pop && !w_legal && (r_drop_count != '1)) r_drop_count <= r_drop_count + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_falafel_config_writer.sv
// tb_falafel_config_writer: directed scenarios plus random traffic against a queue-based model
module tb_falafel_config_writer;
   import falafel_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic              valid = 1'b0, flush = 1'b0;
   logic [DATA_W-1:0] caddr = '0, cdata = '0;
   logic              ready, wr, busy, err;
   logic [DATA_W-1:0] ao, dout, eaddr;

   logic              g_valid = 1'b0;
   logic [DATA_W-1:0] g_addr = '0, g_data = '0;
   logic              g_ready, g_wr, g_busy, g_err;
   logic [DATA_W-1:0] g_ao, g_do, g_ea;

`ifdef FALAFEL_CFG_WRITER_STATS_EN
   logic [31:0] wrc, g_wrc;
   logic [15:0] drc, g_drc;
`endif

   falafel_config_writer #(.FIFO_DEPTH(4), .GAP_CYCLES(0), .ADDR_LIMIT(16)) u_dut (
      .clk_i(clk), .rst_i(rst), .cmd_valid_i(valid), .cmd_ready_o(ready),
      .cmd_addr_i(caddr), .cmd_data_i(cdata), .flush_i(flush), .write_o(wr),
      .addr_o(ao), .data_o(dout), .busy_o(busy), .err_o(err), .err_addr_o(eaddr)
`ifdef FALAFEL_CFG_WRITER_STATS_EN
      , .wr_count_o(wrc), .drop_count_o(drc)
`endif
   );

   falafel_config_writer #(.FIFO_DEPTH(4), .GAP_CYCLES(2), .ADDR_LIMIT(16)) u_gap (
      .clk_i(clk), .rst_i(rst), .cmd_valid_i(g_valid), .cmd_ready_o(g_ready),
      .cmd_addr_i(g_addr), .cmd_data_i(g_data), .flush_i(1'b0), .write_o(g_wr),
      .addr_o(g_ao), .data_o(g_do), .busy_o(g_busy), .err_o(g_err), .err_addr_o(g_ea)
`ifdef FALAFEL_CFG_WRITER_STATS_EN
      , .wr_count_o(g_wrc), .drop_count_o(g_drc)
`endif
   );

   int n_assert = 0;
   int n_fail   = 0;

   // model of u_dut: accepted-but-unissued commands in order, plus sticky error state
   logic [2*DATA_W-1:0] q[$];
   bit                  m_err = 1'b0;
   logic [DATA_W-1:0]   m_eaddr = '0;
   int                  m_wr = 0;
   int                  m_drop = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drop(input logic [DATA_W-1:0] a);
      if (!m_err) m_eaddr = a;
      m_err = 1'b1;
      m_drop++;
   endtask

   task automatic resolve_illegal();
      logic [2*DATA_W-1:0] c;
      while (q.size() > 0 && q[0][15:8] >= 8'd16) begin
         c = q.pop_front();
         drop(c[15:8]);
      end
   endtask

   task automatic model_reset();
      q.delete();
      m_err = 1'b0;
      m_eaddr = '0;
      m_wr = 0;
      m_drop = 0;
   endtask

   // one clock: capture handshake before the edge, compare any pulse against the model after it
   task automatic tick();
      bit                  acc;
      bit                  fl;
      logic [2*DATA_W-1:0] c;
      logic [2*DATA_W-1:0] e;
      acc = valid && ready;
      fl  = flush;
      c   = {caddr, cdata};
      @(posedge clk);
      #1;
      if (wr) begin
         resolve_illegal();
         e = (q.size() > 0) ? q[0] : 16'hxxxx;
         n_assert++;
         assert (q.size() > 0 && {ao, dout} === e) else begin
            n_fail++;
            $error("FAIL write_order observed=%h expected=%h", {ao, dout}, e);
         end
         if (q.size() > 0) void'(q.pop_front());
         m_wr++;
      end
      if (fl) q.delete();
      else if (acc) q.push_back(c);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      model_reset();
      tick();
      tick();
      rst = 1'b0;
   endtask

   initial begin
      model_reset();
      repeat (3) tick();
      rst = 1'b0;
      check("rst_ready", ready, 1);
      check("rst_write", wr, 0);
      check("rst_busy", busy, 0);
      check("rst_err", err, 0);
      check("rst_err_addr", eaddr, 0);
      check("rst_addr", ao, 0);
      check("rst_data", dout, 0);

      // single command: pulse two cycles after acceptance
      valid = 1'b1; caddr = 8'd3; cdata = 8'hA5;
      tick();
      valid = 1'b0;
      check("s1_no_pulse_n1", wr, 0);
      tick();
      check("s1_pulse_n2", wr, 1);
      check("s1_addr", ao, 8'd3);
      check("s1_data", dout, 8'hA5);
      tick();
      check("s1_single", wr, 0);
      check("s1_busy", busy, 0);

      // four back-to-back commands give four consecutive pulses
      do_reset();
      for (int k = 0; k < 6; k++) begin
         valid = (k < 4); caddr = 8'(4 + k); cdata = 8'(8'h10 + k);
         tick();
         check("s2_ready", ready, 1);
         check("s2_pulse", wr, (k >= 1 && k <= 4));
         if (k >= 1 && k <= 4) check("s2_addr", ao, 8'(4 + k - 1));
      end
      valid = 1'b0;
      check("s2_count", m_wr, 4);
`ifdef FALAFEL_CFG_WRITER_STATS_EN
      check("s2_wr_count", wrc, 4);
      check("s2_drop_count", drc, 0);
`endif

      // out-of-range addresses are dropped, only the legal one pulses
      for (int k = 0; k < 5; k++) begin
         valid = (k < 3); caddr = (k == 0) ? 8'd16 : (k == 1) ? 8'd20 : 8'd2; cdata = 8'h77;
         tick();
         check("s4_pulse", wr, (k == 3));
         if (k == 3) check("s4_addr", ao, 8'd2);
      end
      valid = 1'b0;
      check("s4_err", err, 1);
      check("s4_err_addr", eaddr, 8'd16);
      check("s4_model_err_addr", eaddr, m_eaddr);
`ifdef FALAFEL_CFG_WRITER_STATS_EN
      check("s4_drop_count", drc, 2);
      check("s4_wr_count", wrc, 5);
`endif

      // flush during the first pulse leaves exactly one pulse
      for (int k = 0; k < 6; k++) begin
         valid = (k < 3); caddr = 8'(k + 1); cdata = 8'(8'h50 + k); flush = (k == 2);
         tick();
         check("s5_pulse", wr, (k == 1));
      end
      valid = 1'b0; flush = 1'b0;
      check("s5_busy", busy, 0);
      check("s5_ready", ready, 1);
      check("s5_err_kept", err, 1);

      // gap of two: pulses 3 cycles apart, FIFO fills and stalls the source
      begin
         int sent;
         bit acc;
         sent = 0;
         for (int k = 0; k < 20; k++) begin
            g_valid = (sent < 6); g_addr = 8'(sent); g_data = 8'(8'h40 + sent);
            acc = g_valid && g_ready;
            tick();
            if (acc) sent++;
            check("s3_pulse", g_wr, (k % 3 == 1) && (k <= 16));
            if ((k % 3 == 1) && (k <= 16)) begin
               check("s3_addr", g_ao, 8'((k - 1) / 3));
               check("s3_data", g_do, 8'(8'h40 + (k - 1) / 3));
            end
            if (k == 4) check("s3_ready_k4", g_ready, 1);
            if (k == 5) check("s3_stall_k5", g_ready, 0);
            if (k == 6) check("s3_stall_k6", g_ready, 0);
            if (k == 7) check("s3_ready_k7", g_ready, 1);
            if (k == 18) check("s3_busy_gap", g_busy, 1);
            if (k == 19) check("s3_busy_done", g_busy, 0);
         end
         g_valid = 1'b0;
         check("s3_sent", sent, 6);
      end

      // asynchronous reset in the middle of a burst
      valid = 1'b1;
      for (int k = 0; k < 3; k++) begin
         caddr = 8'(k); cdata = 8'(8'h60 + k);
         tick();
      end
      valid = 1'b0;
      check("s6_pulse_before", wr, 1);
      #2 rst = 1'b1;
      #1;
      check("s6_async_drop", wr, 0);
      check("s6_busy", busy, 0);
      model_reset();
      tick();
      tick();
      rst = 1'b0;
      for (int k = 0; k < 5; k++) begin
         tick();
         check("s6_quiet", wr, 0);
      end
      check("s6_err_cleared", err, 0);

      // random traffic, some addresses out of range
      for (int i = 0; i < 300; i++) begin
         valid = 1'($urandom_range(0, 1));
         caddr = 8'($urandom_range(0, 23));
         cdata = 8'($urandom);
         tick();
      end
      valid = 1'b0;
      repeat (12) tick();
      resolve_illegal();
      check("rnd_drained", q.size(), 0);
      check("rnd_busy", busy, 0);
      check("rnd_err", err, m_err);
      check("rnd_err_addr", eaddr, m_eaddr);
`ifdef FALAFEL_CFG_WRITER_STATS_EN
      check("rnd_wr_count", wrc, m_wr);
      check("rnd_drop_count", drc, m_drop);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
